// File: rtl/dma_regfile_bus_if.sv
// Bus master handshake bundle for the DMA register file.
// Master drives req/we/io/addr/wdata; slave returns rdata/ack.
interface dma_regfile_bus_if #(
  parameter int DATA_W = 32,
  parameter int BUS_AW = 8
);
  logic              bus_req;
  logic              bus_we;
  logic              bus_io;
  logic [BUS_AW-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_io,
    output bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_io,
    input  bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/dma_regfile_bus.sv
// DMA register file: 2 comb read ports, 1-cycle add/sub, load/store
// bus master with req/ack, timeout and sticky err. Ports: rd_*, op_*, bus, busy, err.
module dma_regfile_bus #(
  parameter int DATA_W  = 32,
  parameter int AW      = 4,
  parameter int BUS_AW  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op,
  input  logic [1:0]        op_type,
  input  logic [AW-1:0]     src_a,
  input  logic [AW-1:0]     src_b,
  input  logic [AW-1:0]     dst,
  input  logic [BUS_AW-1:0] bus_addr_in,
  dma_regfile_bus_if.master bus,
  output logic              busy,
  output logic              err
);

  localparam int NREG = 2 ** AW;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_STORE_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_dst;
  logic              r_err;
  logic              r_we;
  logic              r_io;
  logic [BUS_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_legal;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_rf_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_latch;
  logic              w_set_err;
  logic              w_cnt_inc;

  assign rd_data_a = r_regs[rd_addr_a];
  assign rd_data_b = r_regs[rd_addr_b];

  assign op_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = op_valid && op_ready;
  assign w_legal  = (op_type == 2'b00) || (op_type == 2'b11);
  assign w_op_a   = r_regs[src_a];
  assign w_op_b   = r_regs[src_b];

  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;
  assign bus.bus_req   = (r_state != S_IDLE);
  assign bus.bus_we    = r_we;
  assign bus.bus_io    = r_io;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rf_we   = 1'b0;
    w_waddr   = dst;
    w_wdata   = '0;
    w_latch   = 1'b0;
    w_set_err = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            op[1]: begin
              w_rf_we = 1'b1;
              w_waddr = dst;
              w_wdata = op[0] ? (w_op_a - w_op_b)
                              : (w_op_a + w_op_b);
            end
            (!op[1] && w_legal): begin
              w_latch = 1'b1;
              w_next  = op[0] ? S_LOAD_WAIT
                              : S_STORE_WAIT;
            end
            (!op[1] && !w_legal): begin
              w_set_err = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD_WAIT, S_STORE_WAIT: begin
        if (bus.bus_ack) begin
          w_next = S_IDLE;
          if (r_state == S_LOAD_WAIT) begin
            w_rf_we = 1'b1;
            w_waddr = r_dst;
            w_wdata = bus.bus_rdata;
          end
        end else if (r_cnt == TMAX) begin
          w_next    = S_IDLE;
          w_set_err = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        r_regs[k] <= DATA_W'(k);
      r_cnt   <= '0;
      r_dst   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_rf_we)
        r_regs[w_waddr] <= w_wdata;
      if (w_latch) begin
        r_addr <= bus_addr_in;
        r_we   <= ~op[0];
        r_io   <= op_type[0];
        r_dst  <= dst;
        if (!op[0])
          r_wdata <= w_op_a;
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_set_err)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_regfile_bus.sv
// Randomized bench for dma_regfile_bus against a
// transaction-level register/err model.
module tb_dma_regfile_bus;

  localparam int DATA_W  = 32;
  localparam int AW      = 4;
  localparam int BUS_AW  = 8;
  localparam int TIMEOUT = 16;
  localparam int NREG    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              op_valid, op_ready;
  logic [1:0]        op, op_type;
  logic [AW-1:0]     src_a, src_b, dst;
  logic [BUS_AW-1:0] bus_addr_in;
  logic              busy, err;

  dma_regfile_bus_if #(
    .DATA_W(DATA_W),
    .BUS_AW(BUS_AW)
  ) bif ();

  dma_regfile_bus #(
    .DATA_W(DATA_W),
    .AW(AW),
    .BUS_AW(BUS_AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op(op),
    .op_type(op_type),
    .src_a(src_a),
    .src_b(src_b),
    .dst(dst),
    .bus_addr_in(bus_addr_in),
    .bus(bif),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_err;
  int                n_chk = 0;
  int                n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++)
      m_regs[k] = DATA_W'(k);
    m_err = 1'b0;
  endtask

  task automatic scan();
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NREG - 1 - i);
      #1;
      check("scan_a", rd_data_a, m_regs[i]);
      check("scan_b", rd_data_b, m_regs[NREG-1-i]);
    end
  endtask

  task automatic run_op(input logic [1:0]        o,
                        input logic [1:0]        t,
                        input logic [AW-1:0]     sa,
                        input logic [AW-1:0]     sb,
                        input logic [AW-1:0]     d,
                        input logic [BUS_AW-1:0] ad,
                        input int                ackdly,
                        input logic [DATA_W-1:0] rdat);
    logic [DATA_W-1:0] va, vb;
    int  exp_cyc, cyc;
    bit  acked;
    @(negedge clk);
    op_valid = 1'b1;
    op = o; op_type = t;
    src_a = sa; src_b = sb; dst = d;
    bus_addr_in = ad;
    va = m_regs[sa];
    vb = m_regs[sb];
    #1 check("op_ready_idle", op_ready, 1);
    @(negedge clk);
    op_valid = 1'b0;
    if (o[1]) begin
      m_regs[d] = o[0] ? va - vb : va + vb;
      check("alu_busy", busy, 0);
      check("alu_ready", op_ready, 1);
    end else if (t == 2'b01 || t == 2'b10) begin
      m_err = 1'b1;
      check("ill_req", bif.bus_req, 0);
      check("ill_busy", busy, 0);
    end else begin
      check("xfer_req", bif.bus_req, 1);
      check("xfer_we", bif.bus_we, !o[0]);
      check("xfer_io", bif.bus_io, t[0]);
      check("xfer_addr", bif.bus_addr, ad);
      if (!o[0]) check("xfer_wdata", bif.bus_wdata, va);
      acked   = (ackdly < TIMEOUT);
      exp_cyc = acked ? ackdly + 1 : TIMEOUT;
      cyc = 0;
      while (bif.bus_req === 1'b1 && cyc < TIMEOUT + 4) begin
        if (cyc == ackdly) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rdat;
        end
        op_valid = 1'b1;
        #1;
        check("wait_ready", op_ready, 0);
        check("wait_busy", busy, 1);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        op_valid = 1'b0;
        cyc++;
      end
      check("req_cycles", 64'(cyc), 64'(exp_cyc));
      if (acked && o == 2'b01) m_regs[d] = rdat;
      if (!acked) m_err = 1'b1;
      check("done_req", bif.bus_req, 0);
      check("done_ready", op_ready, 1);
      check("hold_addr", bif.bus_addr, ad);
      check("hold_we", bif.bus_we, !o[0]);
    end
    check("err", err, m_err);
    rd_addr_a = d;
    #1 check("rd_dst", rd_data_a, m_regs[d]);
  endtask

  logic [1:0]        r_o, r_t;
  logic [AW-1:0]     r_sa, r_sb, r_d;
  logic [BUS_AW-1:0] r_ad;
  logic [DATA_W-1:0] r_rd;

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; op = 2'b00; op_type = 2'b00;
    src_a = '0; src_b = '0; dst = '0;
    bus_addr_in = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    bif.bus_ack = 1'b0;
    bif.bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("ready_in_rst", op_ready, 0);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_req", bif.bus_req, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 1);
    check("rst_addr", bif.bus_addr, 0);
    check("rst_wdata", bif.bus_wdata, 0);
    check("rst_we", bif.bus_we, 0);
    rd_addr_a = 4'd7;
    #1 check("rst_r7", rd_data_a, 32'd7);
    scan();

    run_op(2'b10, 2'b00, 4'd3, 4'd5, 4'd9, 8'h00, 0, '0);
    rd_addr_a = 4'd9;
    #1 check("add_r9", rd_data_a, 32'd8);
    run_op(2'b11, 2'b00, 4'd2, 4'd5, 4'd1, 8'h00, 0, '0);
    rd_addr_a = 4'd1;
    #1 check("sub_wrap", rd_data_a, 32'hFFFF_FFFD);

    run_op(2'b00, 2'b11, 4'd4, 4'd0, 4'd0, 8'h20, 3, '0);
    run_op(2'b01, 2'b00, 4'd0, 4'd0, 4'd6, 8'h10, 1,
           32'hDEAD_BEEF);
    rd_addr_a = 4'd6;
    #1 check("load_r6", rd_data_a, 32'hDEAD_BEEF);

    run_op(2'b01, 2'b00, 4'd0, 4'd0, 4'd12, 8'h44, 999,
           32'h5555_5555);
    rd_addr_a = 4'd12;
    #1 check("to_r12", rd_data_a, 32'd12);
    check("to_err", err, 1);
    run_op(2'b01, 2'b01, 4'd0, 4'd0, 4'd3, 8'h55, 0,
           32'h1111_1111);
    check("ill_err", err, 1);

    for (int n = 0; n < 150; n++) begin
      r_o  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8)
        r_t = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      else
        r_t = 2'($urandom_range(1, 2));
      r_sa = AW'($urandom);
      r_sb = AW'($urandom);
      r_d  = AW'($urandom);
      r_ad = BUS_AW'($urandom);
      r_rd = $urandom;
      run_op(r_o, r_t, r_sa, r_sb, r_d, r_ad,
             $urandom_range(0, TIMEOUT + 1), r_rd);
    end
    scan();

    @(negedge clk);
    op_valid = 1'b1; op = 2'b01; op_type = 2'b00;
    dst = 4'd7; bus_addr_in = 8'h33;
    @(negedge clk);
    op_valid = 1'b0;
    check("mid_req", bif.bus_req, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mr_busy", busy, 0);
    check("mr_req", bif.bus_req, 0);
    check("mr_err", err, 0);
    check("mr_addr", bif.bus_addr, 0);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("late_busy", busy, 0);
    check("late_ready", op_ready, 1);
    scan();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
